// File: rtl/vending_controller_param.sv
// vending_controller_param
// Parametrised vending controller: N items with per-item inventory, coin or
// card payment, cancel/timeout refund and greedy change paid one coin per
// valid/ready beat. All outputs are registered (one cycle after the inputs
// are sampled).
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   nickel, dime, quarter, dollar      one-cycle coin pulses (5/10/25/100 c)
//   sel_valid, sel_index, pay_card     selection strobe, item, card payment
//   card_balance                       card funds, sampled with sel_valid
//   cancel                             user cancel pulse
//   price_flat                         item i price at [i*PRICE_W +: PRICE_W]
//   restock_valid/index/count          restock request
//   restock_ack                        restock applied
//   vend_valid, vend_index             dispense pulse and item
//   card_debit, card_amt               card charge pulse and amount
//   coin_reject, sel_error             coin returned / selection refused
//   change_valid, change_coin          change coin offer (01 N, 10 D, 11 Q)
//   change_ready                       hopper accepts coin
//   balance, sold_out, busy            credit, empty items, not idle
module vending_controller_param #(
  parameter int NUM_ITEMS   = 8,
  parameter int IDX_W       = 3,
  parameter int PRICE_W     = 9,
  parameter int INV_W       = 3,
  parameter int TIMEOUT_CYC = 40
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           nickel,
  input  logic                           dime,
  input  logic                           quarter,
  input  logic                           dollar,
  input  logic                           sel_valid,
  input  logic [IDX_W-1:0]               sel_index,
  input  logic                           pay_card,
  input  logic [PRICE_W-1:0]             card_balance,
  input  logic                           cancel,
  input  logic [NUM_ITEMS*PRICE_W-1:0]   price_flat,
  input  logic                           restock_valid,
  input  logic [IDX_W-1:0]               restock_index,
  input  logic [INV_W-1:0]               restock_count,
  output logic                           restock_ack,
  output logic                           vend_valid,
  output logic [IDX_W-1:0]               vend_index,
  output logic                           card_debit,
  output logic [PRICE_W-1:0]             card_amt,
  output logic                           coin_reject,
  output logic                           sel_error,
  output logic                           change_valid,
  output logic [1:0]                     change_coin,
  input  logic                           change_ready,
  output logic [PRICE_W-1:0]             balance,
  output logic [NUM_ITEMS-1:0]           sold_out,
  output logic                           busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_VEND    = 2'd2;
  localparam logic [1:0] ST_CHANGE  = 2'd3;

  localparam int SUM_W = PRICE_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYC);
  localparam logic [SUM_W-1:0] BAL_MAX   = {1'b0, {PRICE_W{1'b1}}};
  localparam logic [IDX_W:0]   NUM_L     = (IDX_W + 1)'(NUM_ITEMS);

  // Value in cents of a change-coin code.
  function automatic logic [PRICE_W-1:0] coin_value(input logic [1:0] coin);
    case (coin)
      2'b11:   coin_value = PRICE_W'(25);
      2'b10:   coin_value = PRICE_W'(10);
      2'b01:   coin_value = PRICE_W'(5);
      default: coin_value = {PRICE_W{1'b0}};
    endcase
  endfunction

  // Largest coin not exceeding the remaining credit (nickel as the floor).
  function automatic logic [1:0] greedy_coin(input logic [PRICE_W-1:0] bal);
    if (bal >= PRICE_W'(25)) begin
      greedy_coin = 2'b11;
    end else if (bal >= PRICE_W'(10)) begin
      greedy_coin = 2'b10;
    end else begin
      greedy_coin = 2'b01;
    end
  endfunction

  // Inventory add that clamps at the counter maximum instead of wrapping.
  function automatic logic [INV_W-1:0] sat_add(input logic [INV_W-1:0] a,
                                               input logic [INV_W-1:0] b);
    logic [INV_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    sat_add = s[INV_W] ? {INV_W{1'b1}} : s[INV_W-1:0];
  endfunction

  logic [1:0]                      state_r, state_s;
  logic [PRICE_W-1:0]              balance_r, balance_s;
  logic [NUM_ITEMS-1:0][INV_W-1:0] inv_r, inv_s;
  logic [TMO_W-1:0]                tmo_r, tmo_s, tmo_inc_s;
  logic [IDX_W-1:0]                vend_index_r, vend_index_s;
  logic                            vend_valid_r, card_debit_r, coin_reject_r;
  logic                            sel_error_r, change_valid_r, restock_ack_r, busy_r;
  logic [PRICE_W-1:0]              card_amt_r, card_amt_s;
  logic [1:0]                      change_coin_r;
  logic [NUM_ITEMS-1:0]            sold_out_r, sold_out_s;
  logic                            card_debit_s, coin_reject_s, sel_error_s, restock_ack_s;

  logic [PRICE_W-1:0] sel_price_s, bal_after_s;
  logic               sel_stock_s, sel_in_range_s, rs_go_s;
  logic [SUM_W-1:0]   coin_sum_s, sum_ext_s;
  logic               any_coin_s, overflow_s, coin_ok_s, tmo_hit_s;

  // Price and stock lookup for the selected item, coin arithmetic.
  always_comb begin
    sel_price_s = {PRICE_W{1'b0}};
    sel_stock_s = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      sel_price_s = (sel_index == IDX_W'(i)) ? price_flat[i*PRICE_W +: PRICE_W] : sel_price_s;
      sel_stock_s = (sel_index == IDX_W'(i)) ? (inv_r[i] != {INV_W{1'b0}}) : sel_stock_s;
    end
    sel_in_range_s = ({1'b0, sel_index} < NUM_L);
    any_coin_s = nickel | dime | quarter | dollar;
    coin_sum_s = (nickel  ? SUM_W'(5)   : {SUM_W{1'b0}})
               + (dime    ? SUM_W'(10)  : {SUM_W{1'b0}})
               + (quarter ? SUM_W'(25)  : {SUM_W{1'b0}})
               + (dollar  ? SUM_W'(100) : {SUM_W{1'b0}});
    sum_ext_s  = {1'b0, balance_r} + coin_sum_s;
    overflow_s = (sum_ext_s > BAL_MAX);
    rs_go_s    = (state_r == ST_IDLE) && restock_valid && !sel_valid
                 && ({1'b0, restock_index} < NUM_L);
  end

  // Next-state, credit, inventory and pulse computation.
  always_comb begin
    state_s       = state_r;
    balance_s     = balance_r;
    inv_s         = inv_r;
    tmo_s         = {TMO_W{1'b0}};
    tmo_inc_s     = {TMO_W{1'b0}};
    tmo_hit_s     = 1'b0;
    vend_index_s  = vend_index_r;
    card_debit_s  = 1'b0;
    card_amt_s    = {PRICE_W{1'b0}};
    coin_reject_s = 1'b0;
    sel_error_s   = 1'b0;
    restock_ack_s = 1'b0;
    coin_ok_s     = 1'b0;
    bal_after_s   = balance_r;
    case (state_r)
      ST_IDLE, ST_COLLECT: begin
        // Coins are credited before any same-cycle selection is priced.
        if (any_coin_s) begin
          if (overflow_s) begin
            coin_reject_s = 1'b1;
          end else begin
            coin_ok_s   = 1'b1;
            bal_after_s = sum_ext_s[PRICE_W-1:0];
          end
        end else begin
          bal_after_s = balance_r;
        end
        balance_s = bal_after_s;
        tmo_inc_s = (coin_ok_s || sel_valid) ? {TMO_W{1'b0}} : (tmo_r + TMO_W'(1));
        tmo_hit_s = (state_r == ST_COLLECT) && !coin_ok_s && !sel_valid
                    && (tmo_inc_s == TMO_LIMIT);
        // Cancel outranks a same-cycle selection.
        if ((state_r == ST_COLLECT) && (cancel || tmo_hit_s)) begin
          state_s = ST_CHANGE;
        end else if (sel_valid) begin
          if (!sel_in_range_s || !sel_stock_s) begin
            sel_error_s = 1'b1;
          end else if (pay_card) begin
            if ((state_r == ST_IDLE) && (card_balance >= sel_price_s)) begin
              card_debit_s = 1'b1;
              card_amt_s   = sel_price_s;
              state_s      = ST_VEND;
              vend_index_s = sel_index;
            end else begin
              sel_error_s = 1'b1;
            end
          end else if (bal_after_s >= sel_price_s) begin
            balance_s    = bal_after_s - sel_price_s;
            state_s      = ST_VEND;
            vend_index_s = sel_index;
          end else begin
            sel_error_s = 1'b1;
          end
        end else begin
          state_s = state_r;
        end
        // Any accepted coin leaves IDLE, even alongside a refused selection.
        state_s = ((state_s == ST_IDLE) && coin_ok_s) ? ST_COLLECT : state_s;
        tmo_s   = ((state_r == ST_COLLECT) && (state_s == ST_COLLECT)) ? tmo_inc_s
                                                                       : {TMO_W{1'b0}};
        restock_ack_s = rs_go_s;
        for (int i = 0; i < NUM_ITEMS; i++) begin
          inv_s[i] = (rs_go_s && (restock_index == IDX_W'(i)))
                     ? sat_add(inv_r[i], restock_count) : inv_r[i];
        end
      end
      ST_VEND: begin
        coin_reject_s = any_coin_s;
        for (int i = 0; i < NUM_ITEMS; i++) begin
          inv_s[i] = ((vend_index_r == IDX_W'(i)) && (inv_r[i] != {INV_W{1'b0}}))
                     ? (inv_r[i] - INV_W'(1)) : inv_r[i];
        end
        state_s = (balance_r != {PRICE_W{1'b0}}) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        coin_reject_s = any_coin_s;
        if (balance_r == {PRICE_W{1'b0}}) begin
          state_s = ST_IDLE;
        end else if (change_valid_r && change_ready) begin
          balance_s = balance_r - coin_value(change_coin_r);
          state_s   = (balance_s == {PRICE_W{1'b0}}) ? ST_IDLE : ST_CHANGE;
        end else begin
          state_s = ST_CHANGE;
        end
      end
      default: begin
        state_s   = ST_IDLE;
        balance_s = {PRICE_W{1'b0}};
      end
    endcase
    for (int i = 0; i < NUM_ITEMS; i++) begin
      sold_out_s[i] = (inv_s[i] == {INV_W{1'b0}});
    end
  end

  // State, credit, inventory and registered output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      balance_r      <= {PRICE_W{1'b0}};
      inv_r          <= {(NUM_ITEMS*INV_W){1'b0}};
      tmo_r          <= {TMO_W{1'b0}};
      vend_index_r   <= {IDX_W{1'b0}};
      vend_valid_r   <= 1'b0;
      card_debit_r   <= 1'b0;
      card_amt_r     <= {PRICE_W{1'b0}};
      coin_reject_r  <= 1'b0;
      sel_error_r    <= 1'b0;
      change_valid_r <= 1'b0;
      change_coin_r  <= 2'b00;
      restock_ack_r  <= 1'b0;
      sold_out_r     <= {NUM_ITEMS{1'b1}};
      busy_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      balance_r      <= balance_s;
      inv_r          <= inv_s;
      tmo_r          <= tmo_s;
      vend_index_r   <= vend_index_s;
      vend_valid_r   <= (state_s == ST_VEND);
      card_debit_r   <= card_debit_s;
      card_amt_r     <= card_amt_s;
      coin_reject_r  <= coin_reject_s;
      sel_error_r    <= sel_error_s;
      change_valid_r <= (state_s == ST_CHANGE) && (balance_s != {PRICE_W{1'b0}});
      change_coin_r  <= greedy_coin(balance_s);
      restock_ack_r  <= restock_ack_s;
      sold_out_r     <= sold_out_s;
      busy_r         <= (state_s != ST_IDLE);
    end
  end

  assign restock_ack  = restock_ack_r;
  assign vend_valid   = vend_valid_r;
  assign vend_index   = vend_index_r;
  assign card_debit   = card_debit_r;
  assign card_amt     = card_amt_r;
  assign coin_reject  = coin_reject_r;
  assign sel_error    = sel_error_r;
  assign change_valid = change_valid_r;
  assign change_coin  = change_coin_r;
  assign balance      = balance_r;
  assign sold_out     = sold_out_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_vending_controller_param.sv
// Directed bench for vending_controller_param: a table of single-cycle
// vectors plus hand-written sequences for timeout, restock saturation,
// coin overflow and reset during change payout.
module tb_vending_controller_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        nickel, dime, quarter, dollar;
  logic        sel_valid, pay_card, cancel;
  logic [2:0]  sel_index;
  logic [8:0]  card_balance;
  logic [71:0] price_flat;
  logic        restock_valid;
  logic [2:0]  restock_index, restock_count;
  logic        restock_ack, vend_valid, card_debit, coin_reject, sel_error;
  logic [2:0]  vend_index;
  logic [8:0]  card_amt, balance;
  logic        change_valid, change_ready, busy;
  logic [1:0]  change_coin;
  logic [7:0]  sold_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vending_controller_param dut (
    .clk(clk), .rst_n(rst_n),
    .nickel(nickel), .dime(dime), .quarter(quarter), .dollar(dollar),
    .sel_valid(sel_valid), .sel_index(sel_index), .pay_card(pay_card),
    .card_balance(card_balance), .cancel(cancel), .price_flat(price_flat),
    .restock_valid(restock_valid), .restock_index(restock_index),
    .restock_count(restock_count), .restock_ack(restock_ack),
    .vend_valid(vend_valid), .vend_index(vend_index),
    .card_debit(card_debit), .card_amt(card_amt),
    .coin_reject(coin_reject), .sel_error(sel_error),
    .change_valid(change_valid), .change_coin(change_coin),
    .change_ready(change_ready), .balance(balance),
    .sold_out(sold_out), .busy(busy)
  );

  typedef struct {
    string      name;
    logic [3:0] coins;   // {dollar, quarter, dime, nickel}
    logic       sel;
    logic [2:0] idx;
    logic       card;
    logic [8:0] cbal;
    logic       cancel;
    logic       rs;
    logic [2:0] ridx;
    logic [2:0] rcnt;
    logic       rdy;
    logic       e_vv;
    logic [2:0] e_vidx;
    logic       e_cd;
    logic [8:0] e_camt;
    logic       e_rej;
    logic       e_serr;
    logic       e_cv;
    logic [1:0] e_coin;
    logic [8:0] e_bal;
    logic       e_busy;
    logic       e_ack;
    logic [7:0] e_sold;
  } vec_t;

  vec_t tbl[$];
  vec_t v;

  function automatic vec_t blank(string n, logic [8:0] bal, logic bsy, logic [7:0] sold);
    vec_t r;
    r.name = n; r.coins = 4'd0; r.sel = 1'b0; r.idx = 3'd0; r.card = 1'b0;
    r.cbal = 9'd0; r.cancel = 1'b0; r.rs = 1'b0; r.ridx = 3'd0; r.rcnt = 3'd0;
    r.rdy = 1'b1; r.e_vv = 1'b0; r.e_vidx = 3'd0; r.e_cd = 1'b0; r.e_camt = 9'd0;
    r.e_rej = 1'b0; r.e_serr = 1'b0; r.e_cv = 1'b0; r.e_coin = 2'b00;
    r.e_bal = bal; r.e_busy = bsy; r.e_ack = 1'b0; r.e_sold = sold;
    return r;
  endfunction

  task automatic idle_inputs(input logic rdy);
    {dollar, quarter, dime, nickel} = 4'd0;
    sel_valid = 1'b0; sel_index = 3'd0; pay_card = 1'b0; card_balance = 9'd0;
    cancel = 1'b0; restock_valid = 1'b0; restock_index = 3'd0; restock_count = 3'd0;
    change_ready = rdy;
  endtask

  task automatic apply(input vec_t a);
    {dollar, quarter, dime, nickel} = a.coins;
    sel_valid = a.sel; sel_index = a.idx; pay_card = a.card; card_balance = a.cbal;
    cancel = a.cancel; restock_valid = a.rs; restock_index = a.ridx;
    restock_count = a.rcnt; change_ready = a.rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_vec(input vec_t e);
    logic ok;
    ok = (vend_valid === e.e_vv) && (!e.e_vv || vend_index === e.e_vidx)
      && (card_debit === e.e_cd) && (!e.e_cd || card_amt === e.e_camt)
      && (coin_reject === e.e_rej) && (sel_error === e.e_serr)
      && (change_valid === e.e_cv) && (!e.e_cv || change_coin === e.e_coin)
      && (balance === e.e_bal) && (busy === e.e_busy)
      && (restock_ack === e.e_ack) && (sold_out === e.e_sold);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got vv=%b vi=%0d cd=%b amt=%0d rej=%b serr=%b cv=%b coin=%b bal=%0d busy=%b ack=%b sold=%h expected vv=%b vi=%0d cd=%b amt=%0d rej=%b serr=%b cv=%b coin=%b bal=%0d busy=%b ack=%b sold=%h",
               e.name, vend_valid, vend_index, card_debit, card_amt, coin_reject, sel_error,
               change_valid, change_coin, balance, busy, restock_ack, sold_out,
               e.e_vv, e.e_vidx, e.e_cd, e.e_camt, e.e_rej, e.e_serr, e.e_cv, e.e_coin,
               e.e_bal, e.e_busy, e.e_ack, e.e_sold);
    end
  endtask

  initial begin
    // Prices: item0 50, 1 60, 2 75, 3 100, 4 35, 5 5, 6 200, 7 15
    price_flat = {9'd15, 9'd200, 9'd5, 9'd35, 9'd100, 9'd75, 9'd60, 9'd50};
    rst_n = 1'b0;
    idle_inputs(1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_balance", 32'(balance), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sold_out", 32'(sold_out), 32'hFF);
    chk("rst_pulses", 32'({vend_valid, card_debit, coin_reject, sel_error, change_valid, restock_ack}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    v = blank("rs_item2", 9'd0, 1'b0, 8'hFB); v.rs = 1'b1; v.ridx = 3'd2; v.rcnt = 3'd3; v.e_ack = 1'b1; tbl.push_back(v);
    v = blank("rs_item0", 9'd0, 1'b0, 8'hFA); v.rs = 1'b1; v.ridx = 3'd0; v.rcnt = 3'd7; v.e_ack = 1'b1; tbl.push_back(v);
    v = blank("rs_item1", 9'd0, 1'b0, 8'hF8); v.rs = 1'b1; v.ridx = 3'd1; v.rcnt = 3'd2; v.e_ack = 1'b1; tbl.push_back(v);
    v = blank("q1", 9'd25, 1'b1, 8'hF8); v.coins = 4'b0100; tbl.push_back(v);
    v = blank("q2", 9'd50, 1'b1, 8'hF8); v.coins = 4'b0100; tbl.push_back(v);
    v = blank("q3", 9'd75, 1'b1, 8'hF8); v.coins = 4'b0100; tbl.push_back(v);
    v = blank("q4", 9'd100, 1'b1, 8'hF8); v.coins = 4'b0100; tbl.push_back(v);
    v = blank("sel2_coin", 9'd25, 1'b1, 8'hF8); v.sel = 1'b1; v.idx = 3'd2; v.e_vv = 1'b1; v.e_vidx = 3'd2; tbl.push_back(v);
    v = blank("vend_rs_ignored", 9'd25, 1'b1, 8'hF8); v.rs = 1'b1; v.ridx = 3'd3; v.rcnt = 3'd1; v.e_cv = 1'b1; v.e_coin = 2'b11; tbl.push_back(v);
    v = blank("change_q_done", 9'd0, 1'b0, 8'hF8); tbl.push_back(v);
    v = blank("dime", 9'd10, 1'b1, 8'hF8); v.coins = 4'b0010; tbl.push_back(v);
    v = blank("nickel", 9'd15, 1'b1, 8'hF8); v.coins = 4'b0001; tbl.push_back(v);
    v = blank("cancel", 9'd15, 1'b1, 8'hF8); v.cancel = 1'b1; v.e_cv = 1'b1; v.e_coin = 2'b10; tbl.push_back(v);
    v = blank("hold_dime", 9'd15, 1'b1, 8'hF8); v.rdy = 1'b0; v.e_cv = 1'b1; v.e_coin = 2'b10; tbl.push_back(v);
    v = blank("pay_dime", 9'd5, 1'b1, 8'hF8); v.e_cv = 1'b1; v.e_coin = 2'b01; tbl.push_back(v);
    v = blank("pay_nickel", 9'd0, 1'b0, 8'hF8); tbl.push_back(v);
    v = blank("cancel_idle", 9'd0, 1'b0, 8'hF8); v.cancel = 1'b1; tbl.push_back(v);
    v = blank("rs_with_sel", 9'd0, 1'b0, 8'hF8); v.sel = 1'b1; v.idx = 3'd0; v.card = 1'b1; v.rs = 1'b1; v.ridx = 3'd3; v.rcnt = 3'd1; v.e_serr = 1'b1; tbl.push_back(v);
    v = blank("card_short", 9'd0, 1'b0, 8'hF8); v.sel = 1'b1; v.idx = 3'd1; v.card = 1'b1; v.cbal = 9'd50; v.e_serr = 1'b1; tbl.push_back(v);
    v = blank("card_ok", 9'd0, 1'b1, 8'hF8); v.sel = 1'b1; v.idx = 3'd1; v.card = 1'b1; v.cbal = 9'd90; v.e_cd = 1'b1; v.e_camt = 9'd60; v.e_vv = 1'b1; v.e_vidx = 3'd1; tbl.push_back(v);
    v = blank("card_vend_done", 9'd0, 1'b0, 8'hF8); tbl.push_back(v);
    v = blank("dollar", 9'd100, 1'b1, 8'hF8); v.coins = 4'b1000; tbl.push_back(v);
    v = blank("sel_soldout", 9'd100, 1'b1, 8'hF8); v.sel = 1'b1; v.idx = 3'd3; v.e_serr = 1'b1; tbl.push_back(v);
    v = blank("card_in_collect", 9'd100, 1'b1, 8'hF8); v.sel = 1'b1; v.idx = 3'd0; v.card = 1'b1; v.cbal = 9'd200; v.e_serr = 1'b1; tbl.push_back(v);
    v = blank("cancel_beats_sel", 9'd100, 1'b1, 8'hF8); v.cancel = 1'b1; v.sel = 1'b1; v.idx = 3'd0; v.e_cv = 1'b1; v.e_coin = 2'b11; tbl.push_back(v);
    v = blank("coin_in_change", 9'd75, 1'b1, 8'hF8); v.coins = 4'b0010; v.e_rej = 1'b1; v.e_cv = 1'b1; v.e_coin = 2'b11; tbl.push_back(v);
    v = blank("chg_50", 9'd50, 1'b1, 8'hF8); v.e_cv = 1'b1; v.e_coin = 2'b11; tbl.push_back(v);
    v = blank("chg_25", 9'd25, 1'b1, 8'hF8); v.e_cv = 1'b1; v.e_coin = 2'b11; tbl.push_back(v);
    v = blank("chg_0", 9'd0, 1'b0, 8'hF8); tbl.push_back(v);
    v = blank("coin_sel_short", 9'd25, 1'b1, 8'hF8); v.coins = 4'b0100; v.sel = 1'b1; v.idx = 3'd0; v.e_serr = 1'b1; tbl.push_back(v);
    v = blank("coin_sel_exact", 9'd0, 1'b1, 8'hF8); v.coins = 4'b0100; v.sel = 1'b1; v.idx = 3'd0; v.e_vv = 1'b1; v.e_vidx = 3'd0; tbl.push_back(v);
    v = blank("coin_in_vend", 9'd0, 1'b0, 8'hF8); v.coins = 4'b0001; v.e_rej = 1'b1; tbl.push_back(v);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      step();
      chk_vec(tbl[i]);
    end

    // Timeout refund with the hopper stalled
    idle_inputs(1'b0);
    quarter = 1'b1;
    step();
    chk("tmo_coin", 32'(balance), 32'd25);
    quarter = 1'b0;
    repeat (39) step();
    chk("tmo_early", 32'({change_valid, busy}), 32'b01);
    repeat (2) step();
    chk("tmo_fire", 32'({change_valid, change_coin, balance}), {20'd0, 1'b1, 2'b11, 9'd25});
    for (int k = 0; k < 5; k++) begin
      step();
      chk("tmo_hold", 32'({change_valid, change_coin, balance}), {20'd0, 1'b1, 2'b11, 9'd25});
    end
    change_ready = 1'b1;
    step();
    chk("tmo_paid", 32'({busy, balance}), 32'd0);

    // Restock saturation: 6 + 7 clamps at 7, then seven card sales empty item5
    idle_inputs(1'b1);
    restock_valid = 1'b1; restock_index = 3'd5; restock_count = 3'd6;
    step();
    chk("sat_ack1", 32'(restock_ack), 32'd1);
    restock_count = 3'd7;
    step();
    chk("sat_ack2", 32'({restock_ack, sold_out[5]}), 32'b10);
    for (int k = 1; k <= 7; k++) begin
      idle_inputs(1'b1);
      sel_valid = 1'b1; sel_index = 3'd5; pay_card = 1'b1; card_balance = 9'd5;
      step();
      chk("sat_sale", 32'({card_debit, vend_valid, card_amt}), {21'd0, 1'b1, 1'b1, 9'd5});
      idle_inputs(1'b1);
      step();
      chk("sat_stock", 32'(sold_out[5]), (k == 7) ? 32'd1 : 32'd0);
    end
    sel_valid = 1'b1; sel_index = 3'd5; pay_card = 1'b1; card_balance = 9'd5;
    step();
    chk("sat_empty_sel", 32'({sel_error, vend_valid}), 32'b10);

    // Overflow rejection at 500, then reset in the middle of the payout
    idle_inputs(1'b1);
    dollar = 1'b1;
    repeat (5) step();
    chk("ovf_500", 32'(balance), 32'd500);
    dollar = 1'b0; quarter = 1'b1;
    step();
    chk("ovf_reject", 32'({coin_reject, balance}), {22'd0, 1'b1, 9'd500});
    quarter = 1'b0; cancel = 1'b1;
    step();
    chk("ovf_cancel", 32'({change_valid, change_coin, balance}), {20'd0, 1'b1, 2'b11, 9'd500});
    cancel = 1'b0;
    repeat (2) step();
    chk("ovf_paying", 32'(balance), 32'd450);
    rst_n = 1'b0;
    #1;
    chk("mid_rst", 32'({busy, change_valid, balance, sold_out}), {14'd0, 1'b0, 1'b0, 9'd0, 8'hFF});
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst", 32'({busy, balance}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
